// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the program/data RAM arbiter.
// Read latency bounds size the latency down-counter.
package mem_arb_pkg;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      RD_WAIT = 1'b1
   } state_e;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_D    = 2'd2
   } owner_e;

   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 4;
   localparam int LAT_W      = $clog2(RD_LAT_MAX);

endpackage

// File: rtl/mem_arb_pick.sv
// Priority select between fetch and data requests, with a burst counter
// that forces a fetch grant after MAX_BURST data grants while fetch waits.
module mem_arb_pick #(
   parameter int MAX_BURST = 4
) (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_issue_en,
   input  logic i_if_req,
   input  logic i_d_req,
   output logic o_grant_if,
   output logic o_grant_d
);

   localparam int BW = $clog2(MAX_BURST + 1);

   logic [BW-1:0] r_burst_cnt;
   logic          w_burst_full;

   assign w_burst_full = (r_burst_cnt == BW'(MAX_BURST));

   always_comb begin
      o_grant_d  = i_issue_en & i_d_req  & (~i_if_req | ~w_burst_full);
      o_grant_if = i_issue_en & i_if_req & (~i_d_req  |  w_burst_full);
   end

   // Counts only data grants that pass a waiting fetch.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_burst_cnt <= '0;
      end else if (!i_if_req || o_grant_if) begin
         r_burst_cnt <= '0;
      end else if (o_grant_d && !w_burst_full) begin
         r_burst_cnt <= r_burst_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: one access at a time, fixed read latency,
// read data routed back to whichever requester issued the read.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 16,
   parameter int RD_LAT    = 2,
   parameter int MAX_BURST = 4
) (
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_if_req,
   input  logic [ADDR_W-1:0] i_if_addr,
   output logic              o_if_gnt,
   output logic              o_if_rvalid,
   output logic [DATA_W-1:0] o_if_rdata,
   input  logic              i_d_req,
   input  logic              i_d_we,
   input  logic [ADDR_W-1:0] i_d_addr,
   input  logic [DATA_W-1:0] i_d_wdata,
   output logic              o_d_gnt,
   output logic              o_d_rvalid,
   output logic [DATA_W-1:0] o_d_rdata,
   output logic              o_mem_en,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic [DATA_W-1:0] i_mem_rdata,
   output logic              o_busy
);

   state_e           r_state;
   owner_e           r_owner;
   logic [LAT_W-1:0] r_lat_cnt;

   logic w_issue_en;
   logic w_gnt_if;
   logic w_gnt_d;
   logic w_rd_done;

   // Gating with reset keeps every output quiet while reset is held.
   assign w_issue_en = (r_state == IDLE) & ~i_reset;
   assign w_rd_done  = (r_state == RD_WAIT) && (r_lat_cnt == '0);

   mem_arb_pick #(
      .MAX_BURST (MAX_BURST)
   ) u_pick (
      .i_clock    (i_clock),
      .i_reset    (i_reset),
      .i_issue_en (w_issue_en),
      .i_if_req   (i_if_req),
      .i_d_req    (i_d_req),
      .o_grant_if (w_gnt_if),
      .o_grant_d  (w_gnt_d)
   );

   always_comb begin
      o_if_gnt    = w_gnt_if;
      o_d_gnt     = w_gnt_d;
      o_mem_en    = 1'b0;
      o_mem_we    = 1'b0;
      o_mem_addr  = '0;
      o_mem_wdata = '0;
      if (w_gnt_if) begin
         o_mem_en   = 1'b1;
         o_mem_addr = i_if_addr;
      end else if (w_gnt_d) begin
         o_mem_en    = 1'b1;
         o_mem_we    = i_d_we;
         o_mem_addr  = i_d_addr;
         o_mem_wdata = i_d_we ? i_d_wdata : '0;
      end
   end

   always_comb begin
      o_if_rvalid = w_rd_done && (r_owner == OWN_IF);
      o_d_rvalid  = w_rd_done && (r_owner == OWN_D);
      o_if_rdata  = o_if_rvalid ? i_mem_rdata : '0;
      o_d_rdata   = o_d_rvalid  ? i_mem_rdata : '0;
      o_busy      = (r_state == RD_WAIT);
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state   <= IDLE;
         r_owner   <= OWN_NONE;
         r_lat_cnt <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_gnt_if) begin
                  r_state   <= RD_WAIT;
                  r_owner   <= OWN_IF;
                  r_lat_cnt <= LAT_W'(RD_LAT - 1);
               end else if (w_gnt_d && !i_d_we) begin
                  r_state   <= RD_WAIT;
                  r_owner   <= OWN_D;
                  r_lat_cnt <= LAT_W'(RD_LAT - 1);
               end
            end
            RD_WAIT: begin
               if (r_lat_cnt == '0) begin
                  r_state <= IDLE;
                  r_owner <= OWN_NONE;
               end else begin
                  r_lat_cnt <= r_lat_cnt - 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_owner <= OWN_NONE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus hand-written
// burst and reset-during-read sequences, against a small RAM model.
module tb_mem_arbiter;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 16;
   localparam int RD_LAT = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt, if_rvalid;
   logic [DATA_W-1:0] if_rdata;
   logic              d_req, d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_gnt, d_rvalid;
   logic [DATA_W-1:0] d_rdata;
   logic              mem_en, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              busy;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mem_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_BURST(4)
   ) dut (
      .i_clock(clk), .i_reset(rst),
      .i_if_req(if_req), .i_if_addr(if_addr),
      .o_if_gnt(if_gnt), .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
      .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
      .o_d_gnt(d_gnt), .o_d_rvalid(d_rvalid), .o_d_rdata(d_rdata),
      .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
      .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata), .o_busy(busy)
   );

   // RAM model: write on the issue edge, read data appears RD_LAT cycles after issue.
   logic [DATA_W-1:0] ram [0:255];
   logic [DATA_W-1:0] pipe [0:RD_LAT-1];

   initial begin
      for (int i = 0; i < 256; i++) ram[i] = '0;
      for (int i = 0; i < RD_LAT; i++) pipe[i] = '0;
      ram[8'h05] = 16'hBEEF;
      ram[8'h07] = 16'hCAFE;
      ram[8'h30] = 16'h5A5A;
   end

   always @(posedge clk) begin
      if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
      pipe[0] <= (mem_en && !mem_we) ? ram[mem_addr] : '0;
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign mem_rdata = pipe[RD_LAT-1];

   typedef struct {
      logic              ir;
      logic [ADDR_W-1:0] ia;
      logic              dr;
      logic              dw;
      logic [ADDR_W-1:0] da;
      logic [DATA_W-1:0] dwd;
      logic              e_ig;
      logic              e_dg;
      logic              e_en;
      logic              e_we;
      logic [ADDR_W-1:0] e_addr;
      logic [DATA_W-1:0] e_wd;
      logic              e_busy;
      logic              e_irv;
      logic [DATA_W-1:0] e_ird;
      logic              e_drv;
      logic [DATA_W-1:0] e_drd;
   } vec_t;

   localparam int NV = 19;
   vec_t vecs [NV];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic ir, input logic [ADDR_W-1:0] ia, input logic dr,
                        input logic dw, input logic [ADDR_W-1:0] da, input logic [DATA_W-1:0] dwd);
      if_req  = ir;
      if_addr = ia;
      d_req   = dr;
      d_we    = dw;
      d_addr  = da;
      d_wdata = dwd;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".if_gnt"},    32'(if_gnt),    0);
      chk({tag, ".d_gnt"},     32'(d_gnt),     0);
      chk({tag, ".mem_en"},    32'(mem_en),    0);
      chk({tag, ".mem_we"},    32'(mem_we),    0);
      chk({tag, ".mem_addr"},  32'(mem_addr),  0);
      chk({tag, ".mem_wdata"}, 32'(mem_wdata), 0);
      chk({tag, ".busy"},      32'(busy),      0);
      chk({tag, ".if_rvalid"}, 32'(if_rvalid), 0);
      chk({tag, ".if_rdata"},  32'(if_rdata),  0);
      chk({tag, ".d_rvalid"},  32'(d_rvalid),  0);
      chk({tag, ".d_rdata"},   32'(d_rdata),   0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      string t;
      logic  exp_dg, exp_ig, exp_bz, exp_rv;

      //            ir  ia     dr dw da     dwd       ig dg en we addr   wd        bz irv ird       drv drd
      vecs[0]  = '{0, 8'h00, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000};
      vecs[1]  = '{1, 8'h05, 0, 0, 8'h00, 16'h0000, 1, 0, 1, 0, 8'h05, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000};
      vecs[2]  = '{0, 8'h00, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 8'h00, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000};
      vecs[3]  = '{0, 8'h00, 1, 1, 8'h20, 16'h1234, 0, 0, 0, 0, 8'h00, 16'h0000, 1, 1, 16'hBEEF, 0, 16'h0000};
      vecs[4]  = '{0, 8'h00, 1, 1, 8'h20, 16'h1234, 0, 1, 1, 1, 8'h20, 16'h1234, 0, 0, 16'h0000, 0, 16'h0000};
      vecs[5]  = '{0, 8'h00, 1, 0, 8'h20, 16'h0000, 0, 1, 1, 0, 8'h20, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000};
      vecs[6]  = '{0, 8'h00, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 8'h00, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000};
      vecs[7]  = '{0, 8'h00, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 8'h00, 16'h0000, 1, 0, 16'h0000, 1, 16'h1234};
      vecs[8]  = '{1, 8'h07, 0, 0, 8'h00, 16'h0000, 1, 0, 1, 0, 8'h07, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000};
      vecs[9]  = '{0, 8'h00, 1, 0, 8'h44, 16'h0000, 0, 0, 0, 0, 8'h00, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000};
      vecs[10] = '{0, 8'h00, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 8'h00, 16'h0000, 1, 1, 16'hCAFE, 0, 16'h0000};
      vecs[11] = '{0, 8'h00, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000};
      vecs[12] = '{1, 8'h05, 1, 0, 8'h07, 16'h0000, 0, 1, 1, 0, 8'h07, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000};
      vecs[13] = '{1, 8'h05, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 8'h00, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000};
      vecs[14] = '{1, 8'h05, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 8'h00, 16'h0000, 1, 0, 16'h0000, 1, 16'hCAFE};
      vecs[15] = '{1, 8'h05, 0, 0, 8'h00, 16'h0000, 1, 0, 1, 0, 8'h05, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000};
      vecs[16] = '{0, 8'h00, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 8'h00, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000};
      vecs[17] = '{0, 8'h00, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 8'h00, 16'h0000, 1, 1, 16'hBEEF, 0, 16'h0000};
      vecs[18] = '{0, 8'h00, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000};

      rst = 1'b1;
      drive(0, '0, 0, 0, '0, '0);
      @(negedge clk);
      chk_all_zero("reset");
      @(posedge clk);
      #1 rst = 1'b0;

      for (int v = 0; v < NV; v++) begin
         @(posedge clk);
         #1 drive(vecs[v].ir, vecs[v].ia, vecs[v].dr, vecs[v].dw, vecs[v].da, vecs[v].dwd);
         @(negedge clk);
         t = $sformatf("vec%0d", v);
         chk({t, ".if_gnt"},    32'(if_gnt),    32'(vecs[v].e_ig));
         chk({t, ".d_gnt"},     32'(d_gnt),     32'(vecs[v].e_dg));
         chk({t, ".mem_en"},    32'(mem_en),    32'(vecs[v].e_en));
         chk({t, ".mem_we"},    32'(mem_we),    32'(vecs[v].e_we));
         chk({t, ".mem_addr"},  32'(mem_addr),  32'(vecs[v].e_addr));
         chk({t, ".mem_wdata"}, 32'(mem_wdata), 32'(vecs[v].e_wd));
         chk({t, ".busy"},      32'(busy),      32'(vecs[v].e_busy));
         chk({t, ".if_rvalid"}, 32'(if_rvalid), 32'(vecs[v].e_irv));
         chk({t, ".if_rdata"},  32'(if_rdata),  32'(vecs[v].e_ird));
         chk({t, ".d_rvalid"},  32'(d_rvalid),  32'(vecs[v].e_drv));
         chk({t, ".d_rdata"},   32'(d_rdata),   32'(vecs[v].e_drd));
      end

      // Both requesters held: four data stores, a forced fetch, its read wait, then four more stores.
      for (int c = 0; c < 12; c++) begin
         @(posedge clk);
         #1 drive(1, 8'h30, 1, 1, 8'h40, 16'(16'h0100 + c));
         @(negedge clk);
         exp_ig = (c == 4) || (c == 11);
         exp_dg = (c <= 3) || (c >= 7 && c <= 10);
         exp_bz = (c == 5) || (c == 6);
         exp_rv = (c == 6);
         t = $sformatf("burst%0d", c);
         chk({t, ".if_gnt"},    32'(if_gnt),    32'(exp_ig));
         chk({t, ".d_gnt"},     32'(d_gnt),     32'(exp_dg));
         chk({t, ".busy"},      32'(busy),      32'(exp_bz));
         chk({t, ".if_rvalid"}, 32'(if_rvalid), 32'(exp_rv));
         chk({t, ".if_rdata"},  32'(if_rdata),  exp_rv ? 32'h5A5A : 32'h0);
         chk({t, ".d_rvalid"},  32'(d_rvalid),  0);
         if (exp_dg) chk({t, ".mem_wdata"}, 32'(mem_wdata), 32'(16'h0100 + c));
         if (exp_ig) chk({t, ".mem_addr"},  32'(mem_addr),  32'h30);
      end
      @(posedge clk);
      #1 drive(0, '0, 0, 0, '0, '0);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk_all_zero("burst_drain");

      // Reset while a fetch read is outstanding.
      @(posedge clk);
      #1 drive(1, 8'h10, 0, 0, '0, '0);
      @(negedge clk);
      chk("rst_rd.if_gnt", 32'(if_gnt), 1);
      chk("rst_rd.mem_addr", 32'(mem_addr), 32'h10);
      @(posedge clk);
      #1 drive(0, '0, 0, 0, '0, '0);
      rst = 1'b1;
      #1 chk_all_zero("rst_rd.in_reset");
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_rd.if_rvalid", 32'(if_rvalid), 0);
      chk("rst_rd.busy", 32'(busy), 0);
      @(posedge clk);
      #1 drive(0, '0, 1, 1, 8'h22, 16'h7777);
      @(negedge clk);
      chk("rst_rd.idle_d_gnt", 32'(d_gnt), 1);
      chk("rst_rd.idle_mem_we", 32'(mem_we), 1);
      @(posedge clk);
      #1 drive(0, '0, 0, 0, '0, '0);
      @(negedge clk);
      chk_all_zero("final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
